swap_ctrl: RTL and testbench

Multi-cycle sequencer that executes the SISC SWAP instruction against the register file. On a start pulse it latches the Rs and Rt addresses, reads both registers through the two read ports, then writes each value back into the other register on two consecutive cycles. It sits beside the register-address swap mux: it drives that mux's select and the register file's write controls, and returns a done pulse to the control unit.

---
 rtl/swap_ctrl.sv | 111 +++++++++++
 tb/tb_swap_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/swap_ctrl.sv
`default_nettype none
// ============================================================================
// swap_ctrl : SISC SWAP sequencer (latch Rs/Rt, read both, write back crossed)
// Optional: SWAP_R0_PROTECT_EN suppresses write enables targeting R0.
// Rev 1.0
// ============================================================================
module swap_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  output logic              swap_sel,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WR_RS = 3'd2;
  localparam logic [2:0] S_WR_RT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              wr_state;
  logic              done_state;
  logic              r0_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_IDLE && start) begin
        rs_q <= rs_addr;
        rt_q <= rt_addr;
      end
      if (state_q == S_READ) begin
        a_q <= rf_rdata_a;
        b_q <= rf_rdata_b;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  state_nxt = (rs_q == rt_q) ? S_DONE : S_WR_RS;
      S_WR_RS: state_nxt = S_WR_RT;
      S_WR_RT: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_state   = 1'b0;
    done_state = 1'b0;
    swap_sel   = 1'b0;
    rf_wdata   = '0;
    case (state_q)
      S_WR_RS: begin
        wr_state = 1'b1;
        swap_sel = 1'b1;
        rf_wdata = b_q;
      end
      S_WR_RT: begin
        wr_state = 1'b1;
        rf_wdata = a_q;
      end
      S_DONE:  done_state = 1'b1;
      default: ;
    endcase
    rf_waddr = wr_state ? (swap_sel ? rs_q : rt_q) : '0;
  end

`ifdef SWAP_R0_PROTECT_EN
  assign r0_block = (rf_waddr == '0);
`else
  assign r0_block = 1'b0;
`endif

  // A reset arriving at the commit edge must not let a pending write or done escape.
  assign rf_we      = wr_state & ~r0_block & ~rst;
  assign done       = done_state & ~rst;
  assign busy       = (state_q != S_IDLE);
  assign rf_raddr_a = rs_q;
  assign rf_raddr_b = rt_q;

endmodule
`default_nettype wire

// File: tb/tb_swap_ctrl.sv
`default_nettype none
// Scoreboard bench for swap_ctrl: register-file model, swap reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_swap_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef SWAP_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          swap_sel, rf_we, busy, done;

  always #5 clk = ~clk;

  swap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .swap_sel(swap_sel),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we), .busy(busy), .done(done)
  );

  // Register file seen by the DUT; ref_mem is the architectural expectation.
  logic [DW-1:0] rf      [16];
  logic [DW-1:0] ref_mem [16];
  logic          load = 1'b0;
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 16; i++) rf[i] <= ref_mem[i];
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int            cyc;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] old;
    bit            sel;
  } ev_t;
  ev_t q[$];

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int busy_lo = 0, busy_hi = 0, free_at = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic ev_t mk(input int c, input bit w, input logic [AW-1:0] ad,
                             input logic [DW-1:0] d, input logic [DW-1:0] o, input bit s);
    ev_t v;
    v.cyc = c; v.is_wr = w; v.addr = ad; v.data = d; v.old = o; v.sel = s;
    return v;
  endfunction

  // Drive one cycle of inputs and advance the reference model for the upcoming edge.
  task automatic step(input bit s, input bit r, input logic [AW-1:0] a, input logic [AW-1:0] b);
    int e;
    logic [DW-1:0] va, vb;
    e = edge_n + 1;
    rst = r; start = s; rs_addr = a; rt_addr = b;
    if (r) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc >= e - 1) begin
          if (q[i].is_wr) ref_mem[q[i].addr] = q[i].old;
          q.delete(i);
        end
      end
      if (busy_hi > e) busy_hi = e;
      free_at = e + 1;
    end else if (s && e >= free_at) begin
      va = ref_mem[a];
      vb = ref_mem[b];
      busy_lo = e;
      if (a == b) begin
        q.push_back(mk(e + 1, 1'b0, '0, '0, '0, 1'b0));
        busy_hi = e + 2;
        free_at = e + 3;
      end else begin
        if (!(PROT && a == 0)) begin
          q.push_back(mk(e + 1, 1'b1, a, vb, va, 1'b1));
          ref_mem[a] = vb;
        end
        if (!(PROT && b == 0)) begin
          q.push_back(mk(e + 2, 1'b1, b, va, vb, 1'b0));
          ref_mem[b] = va;
        end
        q.push_back(mk(e + 3, 1'b0, '0, '0, '0, 1'b0));
        busy_hi = e + 4;
        free_at = e + 5;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_we"}, {63'd0, rf_we}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_sel"}, {63'd0, swap_sel}, 64'd0);
    chk({tag, "_waddr"}, {60'd0, rf_waddr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, rf_wdata}, 64'd0);
    chk({tag, "_raddr_a"}, {60'd0, rf_raddr_a}, 64'd0);
    chk({tag, "_raddr_b"}, {60'd0, rf_raddr_b}, 64'd0);
  endtask

  // Monitor: compare every cycle's write/done activity against the queued expectations.
  always @(negedge clk) begin : monitor
    bit has, exp_we, exp_done, exp_busy;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        total++;
        bad++;
        $display("FAIL missing_event: expected at cycle %0d, now %0d", q[0].cyc, edge_n);
        void'(q.pop_front());
      end
      has      = (q.size() > 0) && (q[0].cyc == edge_n);
      exp_we   = has && q[0].is_wr;
      exp_done = has && !q[0].is_wr;
      exp_busy = (edge_n >= busy_lo) && (edge_n < busy_hi);
      chk("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (exp_we) begin
        chk("wr_addr", {60'd0, rf_waddr}, {60'd0, q[0].addr});
        chk("wr_data", {32'd0, rf_wdata}, {32'd0, q[0].data});
        chk("swap_sel", {63'd0, swap_sel}, {63'd0, q[0].sel});
      end
      if (has) void'(q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a, b;
    bit s, r;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'h1111_1111;
    ref_mem[7] = 32'h2222_2222;
    ref_mem[9] = 32'hABCD_0001;
    load = 1'b1;
    step(1'b1, 1'b1, 4'd3, 4'd7);
    step(1'b0, 1'b1, 4'd0, 4'd0);
    load = 1'b0;
    mon_en = 1'b1;
    zero_check("reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
      zero_check("idle");
    end

    // Basic swap; addresses wander after acceptance.
    step(1'b1, 1'b0, 4'd3, 4'd7);
    repeat (5) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    // Same register: no writes.
    step(1'b1, 1'b0, 4'd5, 4'd5);
    repeat (3) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
    // Start held through the whole operation.
    repeat (5) step(1'b1, 1'b0, 4'd3, 4'd7);
    repeat (5) step(1'b0, 1'b0, 4'd3, 4'd7);
    // Reset during the WR_RT cycle.
    step(1'b1, 1'b0, 4'd3, 4'd7);
    step(1'b0, 1'b0, 4'd1, 4'd2);
    step(1'b0, 1'b0, 4'd1, 4'd2);
    step(1'b0, 1'b1, 4'd1, 4'd2);
    zero_check("midrst");
    repeat (2) step(1'b0, 1'b0, 4'd0, 4'd0);
    // Reset and start together.
    step(1'b1, 1'b1, 4'd2, 4'd4);
    zero_check("rst_start");
    repeat (2) step(1'b0, 1'b0, 4'd2, 4'd4);
    // R0 as Rs.
    step(1'b1, 1'b0, 4'd0, 4'd9);
    repeat (5) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));

    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 40) == 0);
      a = 4'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
      step(s, r, a, b);
    end
    repeat (8) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));

    chk("queue_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rf_final[%0d]", i), {32'd0, rf[i]}, {32'd0, ref_mem[i]});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
